// File: rtl/mmcm_drp_reconfig.sv
// mmcm_drp_reconfig: rewrites MMCM DRP registers from a stored profile, then waits for lock
module mmcm_drp_reconfig #(
  parameter int N_REGS = 8,
  parameter logic [N_REGS*39-1:0] PROFILE0 = '0,
  parameter logic [N_REGS*39-1:0] PROFILE1 = '0,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_IGNORE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        profile,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        mmcm_rst,
  input  logic        mmcm_locked,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy
);
  localparam int TMAX = DRDY_TIMEOUT > LOCK_TIMEOUT ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);
  localparam int IW = N_REGS > 1 ? $clog2(N_REGS) : 1;
  typedef enum logic [3:0] {IDLE, ASSERT_RST, RD, RD_WAIT, WR, WR_WAIT, RELEASE, LOCK_WAIT, FINISH} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic prof;
  logic [15:0] rdata;
  logic [TW-1:0] tmr;
  logic fail;
  logic [38:0] entry;
  assign entry = prof ? PROFILE1[39*idx +: 39] : PROFILE0[39*idx +: 39];
  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign mmcm_rst = state inside {ASSERT_RST, RD, RD_WAIT, WR, WR_WAIT};
  assign drp_den = state == RD || state == WR;
  assign drp_dwe = state == WR;
  assign drp_daddr = drp_den ? entry[38:32] : '0;
  assign drp_di = drp_dwe ? ((rdata & entry[31:16]) | (entry[15:0] & ~entry[31:16])) : '0;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next-state logic; fail flags a DRDY or lock timeout on the way to FINISH
  always_comb begin
    state_n = state;
    fail = 1'b0;
    case (state)
      IDLE:       state_n = start ? ASSERT_RST : IDLE;
      ASSERT_RST: state_n = RD;
      RD:         state_n = RD_WAIT;
      RD_WAIT:
        if (drp_drdy) state_n = WR;
        else if (tmr == TW'(DRDY_TIMEOUT)) begin
          state_n = FINISH;
          fail = 1'b1;
        end
      WR:         state_n = WR_WAIT;
      WR_WAIT:
        if (drp_drdy) state_n = idx == IW'(N_REGS - 1) ? RELEASE : RD;
        else if (tmr == TW'(DRDY_TIMEOUT)) begin
          state_n = FINISH;
          fail = 1'b1;
        end
      RELEASE:    state_n = LOCK_WAIT;
      LOCK_WAIT:
        if (tmr >= TW'(LOCK_IGNORE) && mmcm_locked) state_n = FINISH;
        else if (tmr == TW'(LOCK_TIMEOUT)) begin
          state_n = FINISH;
          fail = 1'b1;
        end
      FINISH:     state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end
  // request latch, entry index, read-back capture and sticky error
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prof <= 1'b0;
      idx <= '0;
      rdata <= '0;
      error <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        prof <= profile;
        idx <= '0;
        error <= 1'b0;
      end
      if (state == RD_WAIT && drp_drdy) rdata <= drp_do;
      if (state == WR_WAIT && state_n == RD) idx <= idx + 1'b1;
      if (fail) error <= 1'b1;
    end
  // shared wait timer: restarts on every state change and saturates at its ceiling
  always_ff @(posedge clk or posedge rst)
    if (rst) tmr <= '0;
    else tmr <= state_n != state ? '0 : (tmr == TW'(TMAX) ? tmr : tmr + 1'b1);
endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// tb_mmcm_drp_reconfig: directed checks of the DRP reconfiguration sequencer
module tb_mmcm_drp_reconfig;
  localparam logic [77:0] P0 = {7'h09, 16'hFC00, 16'h0000, 7'h08, 16'h1000, 16'h0041};
  localparam logic [77:0] P1 = {7'h0B, 16'h0000, 16'h5555, 7'h0A, 16'h0000, 16'hAAAA};
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, profile = 1'b0, mmcm_locked = 1'b0;
  logic busy, done, error, mmcm_rst, drp_den, drp_dwe, drp_drdy;
  logic [6:0] drp_daddr;
  logic [15:0] drp_di, drp_do;
  logic [6:0] drop_addr = 7'h7F;
  int n_tests = 0, n_fail = 0, done_cnt = 0, pend = 0;
  logic [23:0] ops[$];
  assign drp_do = 16'hFFFF;
  mmcm_drp_reconfig #(
    .N_REGS(2), .PROFILE0(P0), .PROFILE1(P1),
    .DRDY_TIMEOUT(64), .LOCK_TIMEOUT(100), .LOCK_IGNORE(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .profile(profile),
    .busy(busy), .done(done), .error(error), .mmcm_rst(mmcm_rst),
    .mmcm_locked(mmcm_locked), .drp_daddr(drp_daddr), .drp_den(drp_den),
    .drp_dwe(drp_dwe), .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy)
  );
  always #5 clk = ~clk;
  // DRP responder: logs each access, answers with drdy 3 cycles after den unless the read address is dropped
  always @(posedge clk) begin
    drp_drdy <= 1'b0;
    if (rst) pend <= 0;
    else if (drp_den) begin
      ops.push_back({drp_dwe, drp_daddr, drp_di});
      pend <= (!drp_dwe && drp_daddr == drop_addr) ? 0 : 2;
    end else if (pend != 0) begin
      pend <= pend - 1;
      drp_drdy <= pend == 1;
    end
  end
  // done pulse counter
  always @(posedge clk)
    if (done) done_cnt <= done_cnt + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    int k, b, b2, d;
    repeat (3) @(negedge clk);
    chk("reset_outs", {busy, done, error, mmcm_rst, drp_den, drp_dwe, drp_daddr, drp_di}, 0);
    rst = 1'b0;
    @(negedge clk);
    b = ops.size();
    d = done_cnt;
    start = 1'b1;
    profile = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy_rst", {busy, mmcm_rst}, 2'b11);
    for (k = 0; k < 200 && mmcm_rst; k++) @(negedge clk);
    chk("t1_release", {busy, mmcm_rst}, 2'b10);
    repeat (10) @(negedge clk);
    mmcm_locked = 1'b1;
    for (k = 0; k < 50 && !done; k++) @(negedge clk);
    chk("t1_done", {done, error}, 2'b10);
    @(negedge clk);
    mmcm_locked = 1'b0;
    chk("t1_idle", {busy, done}, 2'b00);
    chk("t1_nops", ops.size() - b, 4);
    chk("t1_op0_rd", ops[b][23:16], {1'b0, 7'h08});
    chk("t1_op1_wr", ops[b+1], {1'b1, 7'h08, 16'h1041});
    chk("t1_op2_rd", ops[b+2][23:16], {1'b0, 7'h09});
    chk("t1_op3_wr", ops[b+3], {1'b1, 7'h09, 16'hFC00});
    chk("t1_done_cnt", done_cnt - d, 1);
    drop_addr = 7'h09;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 200 && !(drp_den && !drp_dwe && drp_daddr == 7'h09); k++) @(negedge clk);
    chk("t2_rd2", {drp_den, drp_dwe, drp_daddr}, {1'b1, 1'b0, 7'h09});
    @(negedge clk);
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t2_latency", k, 65);
    chk("t2_err", {done, error, mmcm_rst}, 3'b110);
    @(negedge clk);
    chk("t2_idle_sticky", {busy, error}, 2'b01);
    drop_addr = 7'h7F;
    mmcm_locked = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t3_err_clr", error, 0);
    for (k = 0; k < 200 && mmcm_rst; k++) @(negedge clk);
    chk("t3_release", {busy, mmcm_rst}, 2'b10);
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t3_ignore", k > 4 && k < 10, 1);
    chk("t3_done", {done, error}, 2'b10);
    mmcm_locked = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 200 && mmcm_rst; k++) @(negedge clk);
    chk("t3b_release", {busy, mmcm_rst}, 2'b10);
    k = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("t3b_latency", k >= 100 && k <= 102, 1);
    chk("t3b_err", {done, error}, 2'b11);
    @(negedge clk);
    mmcm_locked = 1'b1;
    b = ops.size();
    d = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 200 && !(drp_den && drp_dwe); k++) @(negedge clk);
    chk("t4_wr", {drp_den, drp_dwe}, 2'b11);
    @(negedge clk);
    start = 1'b1;
    profile = 1'b1;
    @(negedge clk);
    start = 1'b0;
    profile = 1'b0;
    chk("t4_busy", busy, 1);
    for (k = 0; k < 200 && !done; k++) @(negedge clk);
    chk("t4_done", {done, error}, 2'b10);
    repeat (4) @(negedge clk);
    chk("t4_idle", busy, 0);
    chk("t4_done_cnt", done_cnt - d, 1);
    chk("t4_nops", ops.size() - b, 4);
    chk("t4_op1_wr", ops[b+1], {1'b1, 7'h08, 16'h1041});
    chk("t4_op3_wr", ops[b+3], {1'b1, 7'h09, 16'hFC00});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 200 && !(drp_den && !drp_dwe); k++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_async", {busy, done, error, mmcm_rst, drp_den, drp_dwe, drp_daddr, drp_di}, 0);
    b2 = ops.size();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_no_access", ops.size() - b2, 0);
    chk("t5_idle", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 200 && !drp_den; k++) @(negedge clk);
    chk("t5_restart", {drp_den, drp_dwe, drp_daddr}, {1'b1, 1'b0, 7'h08});
    for (k = 0; k < 200 && !done; k++) @(negedge clk);
    chk("t5_done", {done, error}, 2'b10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mmcm_drp_reconfig.md
MMCM_DRP_RECONFIG -- requirements
Module: mmcm_drp_reconfig

Interface
REQ-001 SHALL have parameter N_REGS, default 8: number of DRP registers rewritten per profile (1..16).
REQ-002 SHALL have parameter PROFILE0, default all-zero: N_REGS x 39-bit entries {addr[6:0], mask[15:0], data[15:0]}, entry 0 in LSBs.
REQ-003 SHALL have parameter PROFILE1, default all-zero: same layout as PROFILE0.
REQ-004 SHALL have parameter DRDY_TIMEOUT, default 64: maximum cycles to wait for drp_drdy.
REQ-005 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum cycles to wait for mmcm_locked.
REQ-006 SHALL have parameter LOCK_IGNORE, default 4: cycles after MMCM reset release during which mmcm_locked is ignored.
REQ-007 clk  in  1  single clock for all logic; also drives DRP DCLK.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  one-cycle reconfiguration request.
REQ-010 profile  in  1  profile select, sampled with start.
REQ-011 busy  out  1  high while a reconfiguration runs.
REQ-012 done  out  1  one-cycle pulse when a reconfiguration ends.
REQ-013 error  out  1  sticky flag for DRDY or lock timeout.
REQ-014 mmcm_rst  out  1  MMCM RST drive.
REQ-015 mmcm_locked  in  1  MMCM LOCKED.
REQ-016 drp_daddr  out  7; drp_den  out  1; drp_dwe  out  1; drp_di  out  16; drp_do  in  16; drp_drdy  in  1.

Function
REQ-017 SHALL implement states IDLE, ASSERT_RST, RD, RD_WAIT, WR, WR_WAIT, RELEASE, LOCK_WAIT, FINISH.
REQ-018 IDLE: start=1 SHALL latch profile, clear error, clear index, and enter ASSERT_RST; busy=1 and mmcm_rst=1 from the next cycle.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 ASSERT_RST SHALL last exactly one cycle, then enter RD.
REQ-021 RD SHALL drive den=1, dwe=0, daddr=entry[index].addr for exactly one cycle, then enter RD_WAIT.
REQ-022 RD_WAIT SHALL capture drp_do on drdy=1 and enter WR.
REQ-023 WR SHALL drive den=1, dwe=1, the same daddr, di=(captured_do & mask) | (data & ~mask) for one cycle; mask bit 1 means keep the existing bit.
REQ-024 WR_WAIT on drdy=1: if index==N_REGS-1, SHALL enter RELEASE; otherwise SHALL increment index and enter RD.
REQ-025 den SHALL be 0 in every state other than RD and WR; dwe SHALL be 0 whenever den=0.
REQ-026 drdy outside RD_WAIT and WR_WAIT SHALL be ignored.
REQ-027 The DRDY timer SHALL count from 0 on RD_WAIT or WR_WAIT entry; reaching DRDY_TIMEOUT without drdy SHALL set error and enter FINISH.
REQ-028 RELEASE SHALL drive mmcm_rst=0 and enter LOCK_WAIT.
REQ-029 LOCK_WAIT SHALL ignore mmcm_locked for the first LOCK_IGNORE cycles, then enter FINISH on locked=1.
REQ-030 LOCK_WAIT SHALL set error and enter FINISH if LOCK_TIMEOUT cycles elapse without lock.
REQ-031 FINISH SHALL pulse done=1 for one cycle, drive mmcm_rst=0, and return to IDLE with busy=0 on the following cycle.
REQ-032 error SHALL remain set until the next accepted start.
REQ-033 Timeout counters SHALL be sized from their parameters, and SHALL saturate rather than wrap.

Reset
REQ-034 rst=1 SHALL asynchronously force state=IDLE, index=0, busy=0, done=0, error=0, mmcm_rst=0, den=0, dwe=0, daddr=0, di=0.
REQ-035 rst mid-operation SHALL abort the sequence with no further DRP access; MMCM contents are then undefined, and a new start is required.

Verification
REQ-036 N_REGS=2, profile=0, DRP model (drdy 3 cycles after den, read value 16'hFFFF), entries {7'h08, 16'h1000, 16'h0041} and {7'h09, 16'hFC00, 16'h0000} -> writes 16'hFFFF->di 16'h1041 at 7'h08 and 16'hFC00 at 7'h09, in RD,WR,RD,WR order; locked asserted 10 cycles after release -> one done pulse with error=0.
REQ-037 drdy never returns on the second read, DRDY_TIMEOUT=64 -> error=1 and done pulses 65 cycles after RD_WAIT entry; mmcm_rst=0; busy=0 on the next cycle.
REQ-038 locked held at 1 throughout -> done is not issued before LOCK_IGNORE cycles after release; locked held at 0 with LOCK_TIMEOUT=100 -> error=1.
REQ-039 start pulsed during WR_WAIT with profile=1 -> ignored; the sequence completes with profile 0 entries and exactly one done pulse.
REQ-040 rst asserted while in RD_WAIT -> all outputs return to reset values in the same cycle; start after release -> the sequence restarts at entry 0.
